sha_msg_schedule: RTL
=====================

// Module: sha_msg_schedule
// PURPOSE
//  SHA-256 message-schedule generator; sits directly upstream of sha_math.
//  Loads one 512-bit padded block and emits W_t for t = 0..63, one word per accepted handshake.
//  Drives the W and cycle inputs of sha_math for each compression round.
//  Uses a 16-word sliding window; no 64-word storage.
// PARAMETERS
//  NUM_ROUNDS  64  number of W words emitted per block (fixed at 64 for SHA-256)
// PORTS
//  clk        in   1    system clock, rising edge
//  n_rst      in   1    asynchronous active-low reset
//  start      in   1    load block_in and begin; sampled only in IDLE
//  block_in   in   512  padded message block; word j = block_in[32*j+31:32*j], so W0 = block_in[31:0]
//  w_ready    in   1    consumer (sha_math control) accepts the current word
//  W_out      out  64   {K_t or 32'h0, W_t}; feeds sha_math.W
//  cycle      out  6    round index t of the word on W_out; feeds sha_math.cycle
//  w_valid    out  1    W_out/cycle hold a valid round word
//  busy       out  1    high in RUN and DONE
//  done       out  1    one-cycle pulse after W63 is accepted
// BEHAVIOUR
//  Reset (async, n_rst=0): state=IDLE; window cleared; W_out=0, cycle=0, w_valid=0, busy=0, done=0.
//  Reset mid-operation aborts immediately; no done pulse; next start is accepted normally.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: if start -> window[j]=word j (j=0..15), t=0, go to RUN. Otherwise hold.
//   RUN: w_valid=1, W_out[31:0]=window[0], cycle=t.
//        On w_valid&&w_ready: if t==63 go to DONE, else t++ and shift the window.
//        Without w_ready, W_out and cycle stay stable.
//   DONE: done=1, w_valid=0, busy=1 for exactly one cycle, then IDLE.
//  Latency: start accepted in cycle N; W0 is valid in cycle N+1. With w_ready held high:
//   64 words on consecutive cycles, done at N+65, and start can be accepted again in IDLE at N+66.
//  Window shift: window[i] <= window[i+1] for i = 0..14.
//   window[15] <= s1(window[14]) + window[9] + s0(window[1]) + window[0], mod 2^32.
//  s0(x) = ROTR7 ^ ROTR18 ^ SHR3. s1(x) = ROTR17 ^ ROTR19 ^ SHR10. Adds wrap silently; no carry out.
//  The window keeps shifting after t=48; words computed past W63 are never emitted.
//  start in RUN or DONE is ignored; block_in is sampled only on the IDLE start cycle.
//  When w_valid=0: W_out=0 and cycle=0.
// CONFIGURATION
//  SHA_SCHED_KCONST_EN defined:
//   - 64x32 K constant ROM compiled in.
//   - W_out[63:32] = K_t for the current t (K0=428A2F98, K63=C67178F2) while w_valid=1.
//   - sha_math then receives the pre-paired {K,W}.
//  SHA_SCHED_KCONST_EN undefined:
//   - no ROM; W_out[63:32] = 32'h0 always.
//   - sha_math supplies K itself.
// TESTING
//  1. "abc" block (W0=61626380, W1..W14=0, W15=00000018), start, w_ready=1 ->
//     cycle0 W_out[31:0]=61626380; cycle16 W=61626380; cycle17 W=000F0000; done 1 cycle after cycle63.
//  2. Same block with SHA_SCHED_KCONST_EN ->
//     t=0 W_out=64'h428A2F98_61626380; t=63 W_out[63:32]=C67178F2.
//     Without the macro, W_out[63:32]=0 at every t.
//  3. w_ready low for 3 cycles while t=5 -> W_out and cycle=5 stay stable, w_valid=1;
//     resumes with t=6; done still follows t=63.
//  4. start pulsed at t=10 with a different block_in -> ignored; the sequence matches scenario 1; busy stays high.
//  5. n_rst low at t=30 -> outputs 0 and IDLE within the same cycle; no done.
//     A new start gives W0 on the next cycle.
//  6. Two back-to-back blocks, start asserted again in IDLE after done ->
//     second block W0 appears 1 cycle after its start; no leftover window data.

Source files
------------

// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule generator: 16-word sliding window, one W_t per handshake, t = 0..63.
// Optional macro SHA_SCHED_KCONST_EN pairs each word with its round constant K_t on W_out[63:32].
module sha_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         w_ready,
    output logic [63:0]  W_out,
    output logic [5:0]   cycle,
    output logic         w_valid,
    output logic         busy,
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for start; block_in sampled on the start cycle
    // RUN   | presenting W_t for round t, advancing on each accepted word
    // DONE  | one-cycle done pulse after W63 is accepted
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] window [16];
    logic [5:0]  t;
    logic        accept;
    logic        last;
    logic [31:0] k_word;

`ifdef SHA_SCHED_KCONST_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    assign k_word = K_ROM[t];
`else
    assign k_word = 32'h0;
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign accept = (state == RUN) && w_ready;
    assign last   = (t == 6'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The window keeps rolling past t=48; those extra words are never presented.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) window[i] <= 32'h0;
            t <= 6'd0;
        end else if (state == IDLE && start) begin
            for (int j = 0; j < 16; j++) window[j] <= block_in[32*j +: 32];
            t <= 6'd0;
        end else if (accept) begin
            for (int i = 0; i < 15; i++) window[i] <= window[i+1];
            window[15] <= sig1(window[14]) + window[9] + sig0(window[1]) + window[0];
            if (!last) t <= t + 6'd1;
        end
    end

    always_comb begin
        w_valid = (state == RUN);
        busy    = (state != IDLE);
        done    = (state == DONE);
        W_out   = w_valid ? {k_word, window[0]} : 64'h0;
        cycle   = w_valid ? t : 6'd0;
    end

endmodule
